// File: rtl/tero_pkg.sv
// -----------------------------------------------------------------------------
// tero_pkg
// Shared types and helpers for the TERO response builder.
//   - tero_resp_state_t : response builder FSM states
//   - TERO_* defaults   : default loop count, repetition bits, counter width
//   - helper functions  : derive averaging shift, pair count and index widths
//                         from the loop count / repetition bits
// -----------------------------------------------------------------------------
package tero_pkg;

  localparam int TERO_NUM_LOOPS        = 4;
  localparam int TERO_REPETITIONS_BITS = 13;
  localparam int TERO_COUNT_BITS       = 32;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_COMPARE,
    ST_PRESENT,
    ST_WAIT_DONE_LOW
  } tero_resp_state_t;

  // The counter holds REPETITIONS x F_i. REPETITIONS = 2**(REPETITIONS_BITS-1),
  // so the per-loop average is a plain right shift.
  function automatic int avg_shift(int repetitions_bits);
    return repetitions_bits - 1;
  endfunction

  function automatic int pair_count(int num_loops);
    return num_loops / 2;
  endfunction

  // Select is one bit wider than strictly needed so out-of-range indices
  // coming from the FSM are visible and can be flagged.
  function automatic int sel_width(int num_loops);
    return $clog2(num_loops - 1) + 1;
  endfunction

  function automatic int idx_width(int num_loops);
    return (num_loops > 1) ? $clog2(num_loops) : 1;
  endfunction

  function automatic int pair_width(int num_loops);
    return (num_loops / 2 > 1) ? $clog2(num_loops / 2) : 1;
  endfunction

endpackage

// File: rtl/tero_response_builder_if.sv
// -----------------------------------------------------------------------------
// tero_response_builder_if
// Response valid/ready channel of the TERO response builder.
//   response        : NUM_LOOPS/2 response bits
//   response_error  : capture problem in the run that produced this response
//   response_valid  : response/response_error valid
//   response_ready  : consumer accepts when high together with valid
// Modports: master = producer (response builder), slave = consumer.
// -----------------------------------------------------------------------------
interface tero_response_builder_if #(
  parameter int NUM_LOOPS = tero_pkg::TERO_NUM_LOOPS
) ();

  logic [NUM_LOOPS/2-1:0] response;
  logic                   response_error;
  logic                   response_valid;
  logic                   response_ready;

  modport master (
    output response,
    output response_error,
    output response_valid,
    input  response_ready
  );

  modport slave (
    input  response,
    input  response_error,
    input  response_valid,
    output response_ready
  );

endinterface

// File: rtl/tero_avg_regfile.sv
// -----------------------------------------------------------------------------
// tero_avg_regfile
// Per-loop average storage with a capture mask.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en        : capture wr_count >> AVG_SHIFT into avg[wr_idx], set mask bit
//   wr_idx       : loop index to write (already range-checked by the caller)
//   wr_count     : raw shared counter value
//   mask_clr     : clear the whole capture mask (averages are kept)
//   rd_pair      : pair index for the two combinational read ports
//   rd_even      : avg[2*rd_pair]
//   rd_odd       : avg[2*rd_pair+1]
//   mask         : capture mask, one bit per loop
//   dup          : loop wr_idx has already been captured in this run
// -----------------------------------------------------------------------------
module tero_avg_regfile #(
  parameter int NUM_LOOPS  = 4,
  parameter int COUNT_BITS = 32,
  parameter int AVG_SHIFT  = 12,
  parameter int IDX_W      = 2,
  parameter int PAIR_W     = 1,
  parameter int AVG_BITS   = COUNT_BITS - AVG_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [COUNT_BITS-1:0] wr_count,
  input  logic                  mask_clr,
  input  logic [PAIR_W-1:0]     rd_pair,
  output logic [AVG_BITS-1:0]   rd_even,
  output logic [AVG_BITS-1:0]   rd_odd,
  output logic [NUM_LOOPS-1:0]  mask,
  output logic                  dup
);

  logic [AVG_BITS-1:0] avg [NUM_LOOPS];
  logic [IDX_W-1:0]    even_idx;
  logic [IDX_W-1:0]    odd_idx;

  // NOTE: the average array is reset on purpose: the reset state is defined
  // as all-zero averages, which costs flops rather than a RAM macro but keeps
  // the first run after reset deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        avg[i] <= '0;
      end
      mask <= '0;
    end else begin
      if (mask_clr) begin
        mask <= '0;
      end
      if (wr_en) begin
        // Truncating divide by the repetition count.
        avg[wr_idx]  <= AVG_BITS'(wr_count >> AVG_SHIFT);
        mask[wr_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    even_idx = IDX_W'(2 * int'(rd_pair));
    odd_idx  = IDX_W'(2 * int'(rd_pair) + 1);
  end

  assign rd_even = avg[even_idx];
  assign rd_odd  = avg[odd_idx];
  assign dup     = mask[wr_idx];

endmodule

// File: rtl/tero_response_builder.sv
// -----------------------------------------------------------------------------
// tero_response_builder
// Captures the shared TERO oscillation counter per loop, averages it, and after
// the evaluation FSM reports done compares adjacent loop pairs to form the PUF
// response, presented over a valid/ready channel.
//   clk                : clock, rising edge
//   reset_n            : asynchronous active-low reset
//   store_response_puf : one-cycle strobe, capture count_in for select_puf
//   select_puf         : loop index of the current strobe
//   count_in           : shared counter value (REPETITIONS x F_i)
//   done_in            : FSM done level, held until start drops
//   rsp (master)       : response / response_error / response_valid /
//                        response_ready
// -----------------------------------------------------------------------------
module tero_response_builder
  import tero_pkg::*;
#(
  parameter int NUM_LOOPS        = TERO_NUM_LOOPS,
  parameter int REPETITIONS_BITS = TERO_REPETITIONS_BITS,
  parameter int COUNT_BITS       = TERO_COUNT_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           store_response_puf,
  input  logic [$clog2(NUM_LOOPS-1):0]   select_puf,
  input  logic [COUNT_BITS-1:0]          count_in,
  input  logic                           done_in,
  tero_response_builder_if.master        rsp
);

  localparam int AVG_SHIFT = avg_shift(REPETITIONS_BITS);
  localparam int AVG_BITS  = COUNT_BITS - AVG_SHIFT;
  localparam int PAIRS     = pair_count(NUM_LOOPS);
  localparam int IDX_W     = idx_width(NUM_LOOPS);
  localparam int PAIR_W    = pair_width(NUM_LOOPS);

  tero_resp_state_t state;
  tero_resp_state_t state_next;

  logic [PAIR_W-1:0]    pair;
  logic [PAIRS-1:0]     response_q;
  logic                 error_q;
  logic                 valid_q;

  // Sticky problem flags of the run being collected.
  logic                 dup_flag;
  logic                 range_flag;
  // Overruns happen after collection ended, so they belong to the next run:
  // overrun_next gathers them, and is handed to overrun_run when that run's
  // done arrives.
  logic                 overrun_next;
  logic                 overrun_run;

  // FSM decoded controls.
  logic                 in_range;
  logic                 store_hit;
  logic                 range_hit;
  logic                 overrun_hit;
  logic                 start_cmp;
  logic                 cmp_en;
  logic                 last_pair;
  logic                 accept;

  // Regfile interface.
  logic [AVG_BITS-1:0]  rd_even;
  logic [AVG_BITS-1:0]  rd_odd;
  logic [NUM_LOOPS-1:0] mask;
  logic                 dup_hit;

  assign in_range = int'(select_puf) < NUM_LOOPS;

  tero_avg_regfile #(
    .NUM_LOOPS  (NUM_LOOPS),
    .COUNT_BITS (COUNT_BITS),
    .AVG_SHIFT  (AVG_SHIFT),
    .IDX_W      (IDX_W),
    .PAIR_W     (PAIR_W)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (store_hit),
    .wr_idx   (select_puf[IDX_W-1:0]),
    .wr_count (count_in),
    .mask_clr (accept),
    .rd_pair  (pair),
    .rd_even  (rd_even),
    .rd_odd   (rd_odd),
    .mask     (mask),
    .dup      (dup_hit)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample the pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational outputs get a default before the case so no path
  // leaves them unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: begin
        if (done_in) begin
          state_next = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (int'(pair) == PAIRS - 1) begin
          state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (rsp.response_ready) begin
          state_next = done_in ? ST_WAIT_DONE_LOW : ST_COLLECT;
        end
      end
      ST_WAIT_DONE_LOW: begin
        if (!done_in) begin
          state_next = ST_COLLECT;
        end
      end
      default: state_next = ST_COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    store_hit   = 1'b0;
    range_hit   = 1'b0;
    overrun_hit = 1'b0;
    start_cmp   = 1'b0;
    cmp_en      = 1'b0;
    last_pair   = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_COLLECT: begin
        // A store and done in the same cycle: the store is written on this
        // edge and COMPARE reads it from the next cycle on.
        store_hit = store_response_puf & in_range;
        range_hit = store_response_puf & ~in_range;
        start_cmp = done_in;
      end
      ST_COMPARE: begin
        overrun_hit = store_response_puf;
        cmp_en      = 1'b1;
        last_pair   = int'(pair) == PAIRS - 1;
      end
      ST_PRESENT: begin
        overrun_hit = store_response_puf;
        accept      = rsp.response_ready;
      end
      ST_WAIT_DONE_LOW: begin
        overrun_hit = store_response_puf;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pair counter, response assembly, sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair         <= '0;
      response_q   <= '0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      dup_flag     <= 1'b0;
      range_flag   <= 1'b0;
      overrun_next <= 1'b0;
      overrun_run  <= 1'b0;
    end else begin
      if (start_cmp) begin
        pair <= '0;
      end else if (cmp_en) begin
        pair <= pair + 1'b1;
      end

      // Unsigned compare; a tie yields 0.
      if (cmp_en) begin
        response_q[pair] <= rd_even > rd_odd;
      end

      // Error is frozen together with the last pair so both stay stable
      // for the whole time valid is high.
      if (last_pair) begin
        valid_q <= 1'b1;
        error_q <= dup_flag | range_flag | overrun_run | ~&mask;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (store_hit && dup_hit) begin
        dup_flag <= 1'b1;
      end else if (accept) begin
        dup_flag <= 1'b0;
      end

      if (range_hit) begin
        range_flag <= 1'b1;
      end else if (accept) begin
        range_flag <= 1'b0;
      end

      if (start_cmp) begin
        overrun_run  <= overrun_next;
        overrun_next <= 1'b0;
      end else begin
        if (accept) begin
          overrun_run <= 1'b0;
        end
        if (overrun_hit) begin
          overrun_next <= 1'b1;
        end
      end
    end
  end

  assign rsp.response       = response_q;
  assign rsp.response_error = error_q;
  assign rsp.response_valid = valid_q;

endmodule

// File: tb/tb_tero_response_builder.sv
// -----------------------------------------------------------------------------
// tb_tero_response_builder
// Directed and randomized runs of the TERO response builder against a
// loop-average reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_tero_response_builder;

  localparam int NL      = 4;
  localparam int REP_DIV = 4096;  // 2**(13-1)

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  sel = '0;
  logic [31:0] count = '0;
  logic        done = 1'b0;

  tero_response_builder_if #(.NUM_LOOPS(NL)) rsp ();

  tero_response_builder #(
    .NUM_LOOPS        (NL),
    .REPETITIONS_BITS (13),
    .COUNT_BITS       (32)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .store_response_puf (store),
    .select_puf         (sel),
    .count_in           (count),
    .done_in            (done),
    .rsp                (rsp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-loop averages (persist across runs), capture counts
  // per run, and the run's problem conditions.
  int unsigned m_avg [NL];
  int          m_hits[NL];
  bit          m_range;
  bit          m_overrun_run;
  bit          m_overrun_next;

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_avg[i]  = 0;
      m_hits[i] = 0;
    end
    m_range        = 1'b0;
    m_overrun_run  = 1'b0;
    m_overrun_next = 1'b0;
  endtask

  function automatic logic [1:0] exp_resp();
    logic [1:0] r;
    for (int k = 0; k < NL / 2; k++) begin
      r[k] = m_avg[2*k] > m_avg[2*k+1];
    end
    return r;
  endfunction

  function automatic logic exp_err();
    logic e;
    e = m_range | m_overrun_run;
    for (int i = 0; i < NL; i++) begin
      if (m_hits[i] != 1) e = 1'b1;
    end
    return e;
  endfunction

  // Assert reset now (caller positions it), check outputs clear at once.
  task automatic do_reset(int cycles);
    reset_n = 1'b0;
    store = 1'b0;
    done = 1'b0;
    rsp.response_ready = 1'b0;
    #1;
    check("reset_valid", rsp.response_valid, 1'b0);
    check("reset_resp", rsp.response, 2'b00);
    check("reset_err", rsp.response_error, 1'b0);
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One-cycle strobe; the following step deasserts it.
  task automatic store_step(int s, logic [31:0] c, bit with_done);
    @(negedge clk);
    store = 1'b1;
    sel   = 3'(s);
    count = c;
    if (with_done) done = 1'b1;
    if (s < NL) begin
      m_avg[s] = c / REP_DIV;
      m_hits[s]++;
    end else begin
      m_range = 1'b1;
    end
  endtask

  task automatic finish_run(string tag, bit done_already, int ready_wait,
                            int hold_done, int overrun_at);
    logic [1:0] er;
    logic       ee;
    int         lat;
    bit         again;
    if (!done_already) begin
      @(negedge clk);
      store = 1'b0;
      done  = 1'b1;
    end
    m_overrun_run  = m_overrun_next;
    m_overrun_next = 1'b0;
    er  = exp_resp();
    ee  = exp_err();
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      store = 1'b0;
      if (rsp.response_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_resp"}, rsp.response, er);
    check({tag, "_err"}, rsp.response_error, ee);
    for (int c = 0; c < ready_wait; c++) begin
      @(negedge clk);
      store = 1'b0;
      check({tag, "_hold_valid"}, rsp.response_valid, 1'b1);
      check({tag, "_hold_resp"}, rsp.response, er);
      check({tag, "_hold_err"}, rsp.response_error, ee);
      if (c == overrun_at) begin
        store = 1'b1;
        sel   = 3'd2;
        count = $urandom;
        m_overrun_next = 1'b1;
      end
    end
    @(negedge clk);
    store = 1'b0;
    rsp.response_ready = 1'b1;
    @(negedge clk);
    rsp.response_ready = 1'b0;
    check({tag, "_valid_drop"}, rsp.response_valid, 1'b0);
    for (int i = 0; i < NL; i++) m_hits[i] = 0;
    m_range       = 1'b0;
    m_overrun_run = 1'b0;
    again = 1'b0;
    for (int c = 0; c < hold_done; c++) begin
      @(negedge clk);
      if (rsp.response_valid !== 1'b0) again = 1'b1;
    end
    if (hold_done > 0) check({tag, "_no_second"}, again, 1'b0);
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          ord[NL];
    logic [31:0] c[NL];
    bit          wd;

    rsp.response_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Nominal: averages 10,5,2,3 -> 2'b01, with backpressure and held done.
    store_step(0, 32'd40960, 1'b0);
    store_step(1, 32'd20480, 1'b0);
    store_step(2, 32'd8192,  1'b0);
    store_step(3, 32'd12288, 1'b0);
    check("nominal_expect", exp_resp(), 2'b01);
    finish_run("nominal", 1'b0, 10, 20, -1);

    // Tie and truncation, done in the same cycle as the last store.
    store_step(0, 32'd28672,      1'b0);
    store_step(1, 32'd28675,      1'b0);
    store_step(2, 32'hFFFF_FFFF,  1'b0);
    store_step(3, 32'hFFFF_E000,  1'b1);
    finish_run("tie_trunc", 1'b1, 2, 0, -1);

    // Missing loop 3.
    store_step(0, 32'd4096,  1'b0);
    store_step(1, 32'd8192,  1'b0);
    store_step(2, 32'd81920, 1'b0);
    finish_run("missing", 1'b0, 0, 0, -1);

    // Duplicate loop 1, second value wins.
    store_step(0, 32'd32768, 1'b0);
    store_step(1, 32'd8192,  1'b0);
    store_step(1, 32'd81920, 1'b0);
    store_step(2, 32'd4096,  1'b0);
    store_step(3, 32'd4096,  1'b0);
    finish_run("duplicate", 1'b0, 1, 0, -1);

    // Out-of-range select.
    store_step(0, 32'd4096,  1'b0);
    store_step(1, 32'd8192,  1'b0);
    store_step(6, 32'd12288, 1'b0);
    store_step(2, 32'd16384, 1'b0);
    store_step(3, 32'd8192,  1'b0);
    finish_run("range", 1'b0, 0, 0, -1);

    // Reset in the middle of COMPARE, after pair 0 has set response[0].
    store_step(0, 32'd81920, 1'b0);
    store_step(1, 32'd4096,  1'b0);
    store_step(2, 32'd12288, 1'b0);
    store_step(3, 32'd36864, 1'b0);
    @(negedge clk);
    store = 1'b0;
    done  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    do_reset(2);
    store_step(0, 32'd12288, 1'b0);
    store_step(1, 32'd8192,  1'b0);
    store_step(2, 32'd40960, 1'b0);
    store_step(3, 32'd4096,  1'b0);
    finish_run("after_reset", 1'b0, 0, 0, -1);

    // Overrun strobe during PRESENT, reported by the following run.
    store_step(0, 32'd4096,  1'b0);
    store_step(1, 32'd40960, 1'b0);
    store_step(2, 32'd40960, 1'b0);
    store_step(3, 32'd4096,  1'b0);
    finish_run("overrun_cur", 1'b0, 5, 0, 2);
    store_step(0, 32'd8192,  1'b0);
    store_step(1, 32'd4096,  1'b0);
    store_step(2, 32'd4096,  1'b0);
    store_step(3, 32'd8192,  1'b0);
    check("overrun_expect", exp_err(), 1'b0);  // before done hands over overrun
    finish_run("overrun_next", 1'b0, 0, 0, -1);

    // Randomized complete runs: random order, values, ties and handshake.
    for (int r = 0; r < 10; r++) begin
      ord = '{0, 1, 2, 3};
      for (int i = NL - 1; i > 0; i--) begin
        int j;
        int t;
        j = $urandom_range(i, 0);
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
      for (int p = 0; p < NL / 2; p++) begin
        c[2*p] = $urandom;
        if ($urandom_range(3, 0) == 0) begin
          c[2*p+1] = (c[2*p] & 32'hFFFF_F000) | 32'($urandom_range(4095, 0));
        end else begin
          c[2*p+1] = $urandom;
        end
      end
      wd = 1'($urandom_range(1, 0));
      for (int i = 0; i < NL; i++) begin
        store_step(ord[i], c[ord[i]], (i == NL - 1) && wd);
      end
      finish_run("random", wd, $urandom_range(4, 0), $urandom_range(3, 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
